// File: rtl/spi_master_16.sv
// SPI master: one full-duplex DATA_WIDTH-bit word per start request, MSB first,
// with a configurable CPOL/CPHA mode and SCK derived from the system clock.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | ChipSel high, SCK at CPOL, waiting for StartFlag with EN high
//   S_LEAD  | ChipSel low, SCK at CPOL for HALF clocks (CS setup)
//   S_XFER  | 2*DATA_WIDTH SCK toggles, one every HALF clocks
//   S_TRAIL | SCK back at CPOL, CS hold for HALF clocks, then complete
module spi_master_16 #(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int BitRate_Kbps = 3000,
  parameter int CPOL         = 0,
  parameter int CPHA         = 0,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                  CLK_IN,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  StartFlag,
  input  logic [DATA_WIDTH-1:0] Tx_Data,
  output logic                  Busy,
  output logic                  SCK,
  output logic                  MOSI,
  input  logic                  MISO,
  output logic                  ChipSel,
  output logic [DATA_WIDTH-1:0] Rx_Data,
  output logic                  DataValid,
  output logic                  SPI_Done
);

  localparam int HALF_RAW = CLK_FREQ_HZ / (2 * BitRate_Kbps * 1000);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int CW       = $clog2(HALF + 1);
  localparam int NTOG     = 2 * DATA_WIDTH;
  localparam int TW       = $clog2(NTOG + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_HOLD = CW'(HALF);
  localparam logic [TW-1:0] TOG_LAST = TW'(NTOG - 1);
  localparam logic [TW-1:0] TOG_END  = TW'(NTOG);
  localparam logic          SCK_IDLE = (CPOL != 0);
  localparam logic          PHA1     = (CPHA != 0);

  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CW-1:0]           r_cnt;
  logic [TW-1:0]           r_tog;
  logic [TW-1:0]           w_tog_nxt;
  logic                    r_sck;
  logic                    r_cs_n;
  logic                    r_mosi;
  logic                    r_busy;
  logic [DATA_WIDTH-1:0]   r_tx_sh;
  logic [DATA_WIDTH-1:0]   r_rx_sh;
  logic [DATA_WIDTH-1:0]   r_rx_data;
  logic                    r_dv;
  logic                    r_done;
  logic                    w_accept;
  logic                    w_abort;
  logic                    w_tick;
  logic                    w_finish;

  assign w_tog_nxt = r_tog + TW'(1);

  assign Busy      = r_busy;
  assign SCK       = r_sck;
  assign MOSI      = r_mosi;
  assign ChipSel   = r_cs_n;
  assign Rx_Data   = r_rx_data;
  assign DataValid = r_dv;
  assign SPI_Done  = r_done;

  // State register.
  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and the per-cycle strobes that drive the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_abort     = 1'b0;
    w_tick      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (EN && StartFlag) begin
          w_accept    = 1'b1;
          w_state_nxt = S_LEAD;
        end
      end
      S_LEAD: begin
        if (!EN) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        if (!EN) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_tick = 1'b1;
          if (r_tog == TOG_LAST) w_state_nxt = S_TRAIL;
        end
      end
      S_TRAIL: begin
        if (!EN) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_HOLD) begin
          // The extra count past HALF-1 is the single completion cycle.
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Timers, shift registers and bus outputs.
  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      r_cnt     <= '0;
      r_tog     <= '0;
      r_sck     <= SCK_IDLE;
      r_cs_n    <= 1'b1;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_tx_sh   <= '0;
      r_rx_sh   <= '0;
      r_rx_data <= '0;
      r_dv      <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_dv   <= 1'b0;
      r_done <= 1'b0;
      if (w_accept) begin
        // CPHA=0 has already put the MSB on the wire, so pre-shift it out.
        r_tx_sh <= PHA1 ? Tx_Data : {Tx_Data[DATA_WIDTH-2:0], 1'b0};
        r_mosi  <= Tx_Data[DATA_WIDTH-1];
        r_rx_sh <= '0;
        r_busy  <= 1'b1;
        r_cs_n  <= 1'b0;
        r_cnt   <= '0;
        r_tog   <= '0;
      end else if (w_abort) begin
        r_cs_n <= 1'b1;
        r_sck  <= SCK_IDLE;
        r_busy <= 1'b0;
        r_mosi <= 1'b0;
        r_cnt  <= '0;
        r_tog  <= '0;
      end else if (w_finish) begin
        r_cs_n    <= 1'b1;
        r_rx_data <= r_rx_sh;
        r_dv      <= 1'b1;
        r_done    <= 1'b1;
        r_busy    <= 1'b0;
        r_mosi    <= 1'b0;
        r_cnt     <= '0;
        r_tog     <= '0;
      end else begin
        case (r_state)
          S_LEAD: begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
          end
          S_XFER: begin
            if (w_tick) begin
              r_cnt <= '0;
              r_tog <= w_tog_nxt;
              r_sck <= ~r_sck;
              if (w_tog_nxt[0]) begin
                // Leading edge.
                if (!PHA1) begin
                  r_rx_sh <= {r_rx_sh[DATA_WIDTH-2:0], MISO};
                end else begin
                  r_mosi  <= r_tx_sh[DATA_WIDTH-1];
                  r_tx_sh <= {r_tx_sh[DATA_WIDTH-2:0], 1'b0};
                end
              end else begin
                // Trailing edge.
                if (PHA1) begin
                  r_rx_sh <= {r_rx_sh[DATA_WIDTH-2:0], MISO};
                end else if (w_tog_nxt != TOG_END) begin
                  r_mosi  <= r_tx_sh[DATA_WIDTH-1];
                  r_tx_sh <= {r_tx_sh[DATA_WIDTH-2:0], 1'b0};
                end
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_TRAIL: begin
            r_cnt <= r_cnt + CW'(1);
          end
          default: begin
            r_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_master_16.sv
// Bench for spi_master_16: four instances (one per CPOL/CPHA mode) share the
// control inputs; each talks to a behavioural SPI slave or a MOSI->MISO loop.
module tb_spi_master_16;

  localparam int DW   = 16;
  localparam int HALF = 100_000_000 / (2 * 3000 * 1000);
  localparam int LAT  = (2 * DW + 2) * HALF + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          start;
  logic [DW-1:0] tx_data;
  logic          loopback;
  logic [DW-1:0] sl_resp;

  logic          w_sck   [4];
  logic          w_mosi  [4];
  logic          w_miso  [4];
  logic          w_cs    [4];
  logic          w_busy  [4];
  logic          w_dv    [4];
  logic          w_done  [4];
  logic [DW-1:0] w_rx    [4];
  logic [DW-1:0] w_slgot [4];

  int cyc = 0;
  int acc_cyc = 0;
  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Free-running edge count used to time latencies.
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar m = 0; m < 4; m++) begin : g_mode
    localparam logic L_POL = (m / 2) != 0;
    localparam logic L_PHA = (m % 2) != 0;
    logic          sl_miso = 1'b0;
    logic [DW-1:0] sl_rx   = '0;
    logic [DW-1:0] sl_got  = '0;
    int            sl_idx  = DW - 1;

    spi_master_16 #(.CPOL(m / 2), .CPHA(m % 2)) u_dut (
      .CLK_IN    (clk),
      .RST       (rst),
      .EN        (en),
      .StartFlag (start),
      .Tx_Data   (tx_data),
      .Busy      (w_busy[m]),
      .SCK       (w_sck[m]),
      .MOSI      (w_mosi[m]),
      .MISO      (w_miso[m]),
      .ChipSel   (w_cs[m]),
      .Rx_Data   (w_rx[m]),
      .DataValid (w_dv[m]),
      .SPI_Done  (w_done[m])
    );

    assign w_miso[m]  = loopback ? w_mosi[m] : sl_miso;
    assign w_slgot[m] = sl_got;

    // Slave frame start: CPHA=0 slaves present their MSB as soon as selected.
    always @(negedge w_cs[m]) begin
      sl_idx = DW - 1;
      sl_rx  = '0;
      if (!L_PHA) sl_miso = sl_resp[DW-1];
    end

    // Slave edge behaviour, standard SPI mode semantics.
    always @(w_sck[m]) begin
      if (w_cs[m] === 1'b0) begin
        if (w_sck[m] !== L_POL) begin
          if (!L_PHA) sl_rx = {sl_rx[DW-2:0], w_mosi[m]};
          else if (sl_idx >= 0) begin
            sl_miso = sl_resp[sl_idx];
            sl_idx--;
          end
        end else begin
          if (!L_PHA) begin
            sl_idx--;
            if (sl_idx >= 0) sl_miso = sl_resp[sl_idx];
          end else sl_rx = {sl_rx[DW-2:0], w_mosi[m]};
        end
      end
    end

    always @(posedge w_cs[m]) sl_got = sl_rx;
  end

  int   n_done0 = 0;
  int   n_dv    = 0;
  int   rises   = 0;
  int   per_err = 0;
  int   last_rise = 0;
  logic prev_sck0 = 1'b0;
  logic prev_cs0  = 1'b1;

  // Mode-0 pulse and SCK-period monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (w_done[0] === 1'b1) n_done0++;
    for (int m = 0; m < 4; m++) if (w_dv[m] === 1'b1) n_dv++;
    if (w_cs[0] === 1'b0 && prev_cs0 === 1'b1) rises = 0;
    if (w_sck[0] === 1'b1 && prev_sck0 === 1'b0) begin
      if (rises > 0 && (cyc - last_rise) != 2 * HALF) per_err++;
      rises++;
      last_rise = cyc;
    end
    prev_sck0 = w_sck[0];
    prev_cs0  = w_cs[0];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_rx(input logic [DW-1:0] txw, input logic [DW-1:0] resp,
                                             input logic lp);
    return lp ? txw : resp;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_xfer(input logic [DW-1:0] d);
    tx_data = d;
    start   = 1'b1;
    tick(1);
    acc_cyc = cyc;
    start   = 1'b0;
  endtask

  task automatic check_idle_outs(input string tag, input logic [DW-1:0] exp_rx);
    for (int m = 0; m < 4; m++) begin
      check_val($sformatf("%s_sck%0d", tag, m), w_sck[m], (m >= 2) ? 1 : 0);
      check_val($sformatf("%s_cs%0d", tag, m), w_cs[m], 1);
      check_val($sformatf("%s_mosi%0d", tag, m), w_mosi[m], 0);
      check_val($sformatf("%s_busy%0d", tag, m), w_busy[m], 0);
      check_val($sformatf("%s_rx%0d", tag, m), w_rx[m], exp_rx);
      check_val($sformatf("%s_dv%0d", tag, m), w_dv[m], 0);
      check_val($sformatf("%s_done%0d", tag, m), w_done[m], 0);
    end
  endtask

  task automatic wait_done(input string tag, input logic [DW-1:0] txw, input logic [DW-1:0] exp_rx);
    int k = 0;
    while (w_done[0] !== 1'b1 && k < 3 * LAT) begin
      tick(1);
      k++;
    end
    check_val({tag, "_lat"}, cyc - acc_cyc, LAT);
    for (int m = 0; m < 4; m++) begin
      check_val($sformatf("%s_done%0d", tag, m), w_done[m], 1);
      check_val($sformatf("%s_dv%0d", tag, m), w_dv[m], 1);
      check_val($sformatf("%s_rx%0d", tag, m), w_rx[m], exp_rx);
      check_val($sformatf("%s_slv%0d", tag, m), w_slgot[m], txw);
      check_val($sformatf("%s_cs%0d", tag, m), w_cs[m], 1);
      check_val($sformatf("%s_busy%0d", tag, m), w_busy[m], 0);
      check_val($sformatf("%s_sck%0d", tag, m), w_sck[m], (m >= 2) ? 1 : 0);
    end
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] held_rx;
    int            snap;
    int            snap_err;

    rst = 1'b1; en = 1'b1; start = 1'b0; tx_data = '0;
    loopback = 1'b1; sl_resp = '0;
    tick(3);
    check_idle_outs("rst", '0);
    rst = 1'b0;
    tick(2);

    // Loopback, mode 0 period and edge count.
    loopback = 1'b1;
    snap_err = per_err;
    start_xfer(16'hA9A5);
    check_val("t1_busy", w_busy[0], 1);
    check_val("t1_cs", w_cs[0], 0);
    check_val("t1_mosi", w_mosi[0], 1);
    wait_done("t1", 16'hA9A5, model_rx(16'hA9A5, sl_resp, loopback));
    check_val("t1_rises", rises, DW);
    check_val("t1_period", per_err - snap_err, 0);
    tick(1);
    check_val("t1_done_1clk", w_done[0], 0);
    check_val("t1_dv_1clk", w_dv[0], 0);

    // All modes against the behavioural slave.
    loopback = 1'b0;
    sl_resp  = 16'hF0A5;
    tick(2);
    for (int m = 0; m < 4; m++)
      check_val($sformatf("t2_idle_sck%0d", m), w_sck[m], (m >= 2) ? 1 : 0);
    start_xfer(16'hA9A5);
    wait_done("t2", 16'hA9A5, model_rx(16'hA9A5, sl_resp, loopback));
    tick(3);

    // Start while busy is ignored.
    loopback = 1'b1;
    snap = n_done0;
    start_xfer(16'hBEEF);
    tick(99);
    tx_data = 16'h1234;
    start   = 1'b1;
    tick(1);
    start   = 1'b0;
    wait_done("t3", 16'hBEEF, model_rx(16'hBEEF, sl_resp, loopback));
    tick(LAT + 20);
    check_val("t3_one_done", n_done0 - snap, 1);

    // Back-to-back with a one-clock ChipSel gap.
    loopback = 1'b0;
    sl_resp  = 16'h1357;
    start_xfer(16'h00FF);
    wait_done("t4a", 16'h00FF, model_rx(16'h00FF, sl_resp, loopback));
    sl_resp = 16'h8C21;
    start_xfer(16'hFF00);
    for (int m = 0; m < 4; m++)
      check_val($sformatf("t4_cs_low%0d", m), w_cs[m], 0);
    wait_done("t4b", 16'hFF00, model_rx(16'hFF00, sl_resp, loopback));
    tick(2);

    // EN dropped mid-transfer.
    held_rx = w_rx[0];
    snap    = n_dv;
    sl_resp = 16'hAAAA;
    start_xfer(16'h1111);
    tick(199);
    en = 1'b0;
    tick(1);
    check_idle_outs("t5", held_rx);
    tick(20);
    check_val("t5_no_dv", n_dv - snap, 0);
    // EN and StartFlag rising together.
    en = 1'b1;
    start_xfer(16'h2468);
    check_val("t5_same_cyc_busy", w_busy[0], 1);
    wait_done("t5b", 16'h2468, model_rx(16'h2468, sl_resp, loopback));
    tick(2);

    // Asynchronous reset mid-XFER.
    snap = n_done0;
    start_xfer(16'hC3C3);
    tick(300);
    #3;
    rst = 1'b1;
    #1;
    check_idle_outs("t6_rst", '0);
    tick(2);
    rst = 1'b0;
    tick(2);
    check_val("t6_no_done", n_done0 - snap, 0);
    sl_resp = 16'h0F0F;
    start_xfer(16'h5A5A);
    wait_done("t6", 16'h5A5A, model_rx(16'h5A5A, sl_resp, loopback));

    // Randomized words, modes, gaps and ignored starts.
    for (int i = 0; i < 8; i++) begin
      int gap;
      int spur;
      d        = DW'($urandom);
      sl_resp  = DW'($urandom);
      loopback = 1'($urandom_range(0, 1));
      gap      = $urandom_range(0, 4);
      spur     = $urandom_range(0, 1);
      if (gap > 0) tick(gap);
      start_xfer(d);
      if (spur != 0) begin
        tick($urandom_range(20, 500));
        tx_data = ~d;
        start   = 1'b1;
        tick(1);
        start   = 1'b0;
      end
      wait_done($sformatf("rnd%0d", i), d, model_rx(d, sl_resp, loopback));
    end

    tick(5);
    check_val("sck_period_all", per_err, 0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_master_16.md
Name: spi_master_16

Overview:
- SPI master: generates SCK, ChipSel, MOSI and samples MISO for one DATA_WIDTH-bit full-duplex word per start request.
- Pairs with the existing SPI slave on the same bus, using the same CPOL/CPHA mode convention.
- Sits between a local controller (start/data handshake) and the off-chip or on-fabric SPI slave, clocked from the 100 MHz system clock.

Parameters:
- CLK_FREQ_HZ, 100_000_000: system clock frequency.
- BitRate_Kbps, 3000: target SCK rate. HALF = max(1, CLK_FREQ_HZ / (2*BitRate_Kbps*1000)), integer floor; HALF = 16 with defaults.
- CPOL, 0: SCK idle level.
- CPHA, 0: 0 = sample MISO on leading edge; 1 = sample on trailing edge.
- DATA_WIDTH, 16: bits per transfer, sent MSB first.

Ports:
- CLK_IN  in  1  system clock; all logic on posedge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  block enable; low aborts any transfer.
- StartFlag  in  1  one-cycle start request; sampled only in IDLE with EN=1.
- Tx_Data  in  DATA_WIDTH  word to send; captured on the accepted StartFlag cycle.
- Busy  out  1  high from the accept cycle until return to IDLE.
- SCK  out  1  serial clock.
- MOSI  out  1  master data out.
- MISO  in  1  slave data in.
- ChipSel  out  1  active-low select.
- Rx_Data  out  DATA_WIDTH  last completed received word.
- DataValid  out  1  one-cycle pulse when Rx_Data updates.
- SPI_Done  out  1  one-cycle pulse at transfer completion, coincident with DataValid.

Behaviour:
- Reset values:
  - SCK=CPOL, ChipSel=1, MOSI=0, Busy=0, Rx_Data=0, DataValid=0, SPI_Done=0.
  - State IDLE; all counters 0.
- States: IDLE -> LEAD -> XFER -> TRAIL -> IDLE.
- IDLE:
  - StartFlag=1 and EN=1 at an edge: capture Tx_Data into the shift register, Busy=1, ChipSel=0, MOSI=Tx_Data[MSB]. This applies in both modes; for CPHA=1, MOSI is re-driven with the same bit at the first leading edge.
  - Enter LEAD.
- LEAD: hold for HALF clocks (CS setup), SCK=CPOL. Then enter XFER.
- XFER:
  - Half-period counter runs 0..HALF-1; at each wrap SCK toggles. Toggle index t = 1..2*DATA_WIDTH; odd t = leading edge, even t = trailing edge.
  - CPHA=0: MISO is sampled into the receive shift register (shift left, LSB in) in the same cycle SCK toggles on odd t. MOSI advances to the next bit on even t, except t=2*DATA_WIDTH.
  - CPHA=1: MOSI is driven with bit (DATA_WIDTH-1-(t-1)/2) on odd t. MISO is sampled on even t.
  - After t=2*DATA_WIDTH, SCK is back at CPOL; enter TRAIL.
- TRAIL:
  - Hold HALF clocks (CS hold).
  - Then in one cycle: ChipSel=1, Rx_Data<=receive register, DataValid=1, SPI_Done=1, Busy=0, MOSI=0; state IDLE.
- Latency: completion pulses occur exactly (2*DATA_WIDTH+2)*HALF+1 clocks after the accept edge (545 with defaults).
- Next start: StartFlag may be accepted on the cycle after the completion pulse. Minimum ChipSel-high time is 1 clock.
- StartFlag while Busy: ignored, no queuing. Tx_Data changes while Busy have no effect.
- EN low while Busy:
  - Next edge: IDLE, ChipSel=1, SCK=CPOL, Busy=0, MOSI=0.
  - No DataValid or SPI_Done; Rx_Data keeps its previous value.
- RST mid-transfer: outputs return to reset values immediately (asynchronous); no completion pulses.
- StartFlag and EN rising in the same cycle: the start is accepted.
- Bit count: exactly DATA_WIDTH samples per transfer; no wrap-around beyond DATA_WIDTH.

Test Plan:
1. Mode 0, MISO tied to MOSI, Tx_Data=16'hA9A5, StartFlag pulse -> 16 SCK rising edges, period 32 clocks; Rx_Data=16'hA9A5; DataValid and SPI_Done high for one clock exactly 545 clocks after accept.
2. All four CPOL/CPHA combos, behavioural slave returning 16'hF0A5 and checking MOSI=16'hA9A5 -> Rx_Data=16'hF0A5 and slave receives 16'hA9A5 in every mode; SCK idles at CPOL.
3. Second StartFlag with Tx_Data=16'h1234 at clock 100 of a transfer -> ignored; Rx_Data reflects the first word only; exactly one SPI_Done.
4. Back-to-back: StartFlag on the cycle after SPI_Done, Tx_Data=16'h00FF then 16'hFF00 -> two correct words; ChipSel high for exactly 1 clock between them.
5. EN dropped at clock 200 of a transfer -> ChipSel=1, SCK=CPOL, Busy=0 next edge; no DataValid; Rx_Data unchanged.
6. RST asserted asynchronously mid-XFER (between clock edges) -> immediate reset values; after release, a new 16'h5A5A transfer completes correctly.
